gpr_file_sb: RTL and testbench

// - Parametrised general-purpose register file for the 16-bit RISC core; next generation of the 8x16 GPR.
// - Adds the following:
//   - N read and M write ports.
//   - Optional hardwired-zero R0.
//   - Same-cycle write-to-read bypass.
//   - Per-register busy scoreboard, so decode can stall on RAW hazards.
// - Sits between decode (reads, reservations) and writeback (writes).
//

---
 rtl/gpr_file_sb_pkg.sv | 18 +
 rtl/gpr_file_sb_if.sv | 33 +++
 rtl/gpr_file_sb_scoreboard.sv | 54 +++++
 rtl/gpr_file_sb.sv | 90 +++++++++
 tb/tb_gpr_file_sb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_file_sb_pkg.sv
// gpr_pkg: shared constants, types and helpers for the GPR file with scoreboard.
// Contents: default geometry, data/address typedefs, and an address-range check
// that is used wherever DEPTH may not be a power of two.
package gpr_pkg;

  localparam int GPR_WIDTH = 16;
  localparam int GPR_DEPTH = 8;
  localparam int GPR_AW    = $clog2(GPR_DEPTH);

  typedef logic [GPR_WIDTH-1:0] gpr_data_t;
  typedef logic [GPR_AW-1:0]    gpr_addr_t;

  // True when addr names an existing register.
  function automatic logic gpr_addr_valid(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/gpr_file_sb_if.sv
// gpr_file_sb_if: decode/writeback <-> register file bus.
// master: drives write port(s), read requests and reservations (decode/writeback).
// slave : register file; returns read data, read busy flags, rsv_ok and busy_vec.
// Multi-port fields are flattened: port p occupies [p*W +: W].
interface gpr_file_sb_if #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(DEPTH)
);
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic                    rsv_en;
  logic [AW-1:0]           rsv_addr;
  logic                    rsv_ok;
  logic [DEPTH-1:0]        busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ok, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ok, busy_vec
  );
endinterface

// File: rtl/gpr_file_sb_scoreboard.sv
// gpr_scoreboard: per-register busy bits for RAW hazard detection.
// Ports: clk, rst (async, active-high); wr_en_i/wr_addr_i (writeback, clears busy);
// rsv_en_i/rsv_addr_i (issue, sets busy); rsv_ok_o (comb accept); busy_vec_o (state).
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_WR  = 1,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  output logic                 rsv_ok_o,
  output logic [DEPTH-1:0]     busy_vec_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] wr_hit;
  logic             rsv_is_r0;

  always_comb begin
    wr_hit = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en_i[p] && gpr_addr_valid(32'(wr_addr_i[p*AW +: AW]), DEPTH))
        wr_hit[wr_addr_i[p*AW +: AW]] = 1'b1;
    end

    // Hardwired R0 has no producer to wait for, so it is always accepted.
    rsv_is_r0 = (ZERO_R0 != 0) && (rsv_addr_i == '0);

    rsv_ok_o = 1'b0;
    if (rsv_en_i && gpr_addr_valid(32'(rsv_addr_i), DEPTH))
      rsv_ok_o = rsv_is_r0 || !busy_q[rsv_addr_i] || wr_hit[rsv_addr_i];

    // Clear first, then set: a same-cycle write and new reservation leaves
    // the register owned by the new producer.
    busy_d = busy_q & ~wr_hit;
    if (rsv_ok_o && !rsv_is_r0)
      busy_d[rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: parametrised GPR file with N read / M write ports, optional
// hardwired-zero R0, same-cycle write-to-read bypass and a busy scoreboard.
// Ports: clk, rst (async, active-high); bus (gpr_file_sb_if.slave) carrying
// write ports, read ports (comb data + busy), reservation and busy_vec.
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int WIDTH   = GPR_WIDTH,
  parameter int DEPTH   = GPR_DEPTH,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  gpr_file_sb_if.slave bus
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            busy_vec;

  // Storage: ports applied in ascending order so the highest port wins a tie.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (bus.wr_en[p] && gpr_addr_valid(32'(bus.wr_addr[p*AW +: AW]), DEPTH) &&
          !((ZERO_R0 != 0) && (bus.wr_addr[p*AW +: AW] == '0)))
        regs_d[bus.wr_addr[p*AW +: AW]] = bus.wr_data[p*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  gpr_scoreboard #(
    .DEPTH   (DEPTH),
    .NUM_WR  (NUM_WR),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .rsv_en_i   (bus.rsv_en),
    .rsv_addr_i (bus.rsv_addr),
    .rsv_ok_o   (bus.rsv_ok),
    .busy_vec_o (busy_vec)
  );

  assign bus.busy_vec = busy_vec;

  // Read ports: one mux per port.
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             byp_hit;

    assign addr = bus.rd_addr[r*AW +: AW];

    always_comb begin
      data    = '0;
      busy    = 1'b0;
      byp_hit = 1'b0;
      if (bus.rd_en[r] && gpr_addr_valid(32'(addr), DEPTH) &&
          !((ZERO_R0 != 0) && (addr == '0))) begin
        data = regs_q[addr];
        busy = busy_vec[addr];
        if (BYPASS != 0) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == addr)) begin
              data    = bus.wr_data[p*WIDTH +: WIDTH];
              byp_hit = 1'b1;
            end
          end
        end
        // The producer is delivering right now, so the reader need not stall.
        if (byp_hit) busy = 1'b0;
      end
    end

    assign bus.rd_data[r*WIDTH +: WIDTH] = data;
    assign bus.rd_busy[r]                = busy;
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;
  import gpr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpr_file_sb_if #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .NUM_WR(2)) ifa ();
  gpr_file_sb_if #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .NUM_WR(1)) ifb ();

  gpr_file_sb #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .NUM_WR(2), .ZERO_R0(0), .BYPASS(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  gpr_file_sb #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .NUM_WR(1), .ZERO_R0(1), .BYPASS(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  localparam int K_RD = 0, K_RDBUSY = 1, K_RSVOK = 2, K_BUSY = 3;

  typedef struct {
    int        dut;
    int        kind;
    int        idx;
    gpr_data_t exp;
    string     name;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   tests  = 0;
  int   failed = 0;
  gpr_data_t act;

  function automatic gpr_data_t get_act(input int dut, input int kind, input int idx);
    if (dut == 0) begin
      case (kind)
        K_RD:     return ifa.rd_data[idx*16 +: 16];
        K_RDBUSY: return 16'(ifa.rd_busy);
        K_RSVOK:  return 16'(ifa.rsv_ok);
        default:  return 16'(ifa.busy_vec);
      endcase
    end else begin
      case (kind)
        K_RD:     return ifb.rd_data[idx*16 +: 16];
        K_RDBUSY: return 16'(ifb.rd_busy);
        K_RSVOK:  return 16'(ifb.rsv_ok);
        default:  return 16'(ifb.busy_vec);
      endcase
    end
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      me  = q.pop_front();
      act = get_act(me.dut, me.kind, me.idx);
      tests++;
      if (act !== me.exp) begin
        failed++;
        $display("FAIL %s: got %h expected %h", me.name, act, me.exp);
      end
    end
  end

  task automatic chk(input int dut, input int kind, input int idx, input gpr_data_t e,
                     input string n);
    exp_t t;
    t.dut = dut; t.kind = kind; t.idx = idx; t.exp = e; t.name = n;
    q.push_back(t);
  endtask

  task automatic idle();
    ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.rd_en = '0; ifa.rd_addr = '0; ifa.rsv_en = 1'b0; ifa.rsv_addr = '0;
    ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.rd_en = '0; ifb.rd_addr = '0; ifb.rsv_en = 1'b0; ifb.rsv_addr = '0;
  endtask

  task automatic rd_a(input int port, input int addr);
    ifa.rd_en[port] = 1'b1;
    ifa.rd_addr[port*3 +: 3] = 3'(addr);
  endtask

  task automatic wr_a(input int port, input int addr, input gpr_data_t d);
    ifa.wr_en[port] = 1'b1;
    ifa.wr_addr[port*3 +: 3] = 3'(addr);
    ifa.wr_data[port*16 +: 16] = d;
  endtask

  task automatic rd_b(input int port, input int addr);
    ifb.rd_en[port] = 1'b1;
    ifb.rd_addr[port*3 +: 3] = 3'(addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    #1;
    rd_a(0, 3); rd_a(1, 6);
    chk(0, K_RD, 0, 16'h0, "rst_rd0");
    chk(0, K_RD, 1, 16'h0, "rst_rd1");
    chk(0, K_RSVOK, 0, 16'h0, "rst_rsvok");
    chk(0, K_BUSY, 0, 16'h0, "rst_busy_a");
    chk(1, K_BUSY, 0, 16'h0, "rst_busy_b");
    @(negedge clk);
    #2 rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      rd_a(0, i); rd_a(1, 7 - i);
      chk(0, K_RD, 0, 16'h0, "init_rd0");
      chk(0, K_RD, 1, 16'h0, "init_rd1");
      chk(0, K_BUSY, 0, 16'h0, "init_busy");
      step();
    end

    wr_a(0, 3, 16'hA5A5); rd_a(0, 3); rd_a(1, 4);
    chk(0, K_RD, 0, 16'hA5A5, "byp_r3");
    chk(0, K_RD, 1, 16'h0000, "r4_untouched");
    step();
    rd_a(0, 3); ifa.rd_addr[5:3] = 3'd3;
    chk(0, K_RD, 0, 16'hA5A5, "stored_r3");
    chk(0, K_RD, 1, 16'h0000, "rd_en_off");
    step();

    wr_a(0, 5, 16'h1111); wr_a(1, 5, 16'h2222); rd_a(0, 5);
    chk(0, K_RD, 0, 16'h2222, "dual_wr_byp");
    step();
    rd_a(0, 5);
    chk(0, K_RD, 0, 16'h2222, "dual_wr_stored");
    step();

    ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd2;
    chk(0, K_RSVOK, 0, 16'h1, "rsv_r2_ok");
    chk(0, K_BUSY, 0, 16'h00, "rsv_r2_pre");
    step();
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd2; rd_a(1, 2);
    chk(0, K_RSVOK, 0, 16'h0, "rsv_r2_again");
    chk(0, K_BUSY, 0, 16'h04, "busy_r2");
    chk(0, K_RDBUSY, 0, 16'h2, "rd_busy_r2");
    step();
    wr_a(0, 2, 16'h0BEE); ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd2; rd_a(0, 2);
    chk(0, K_RSVOK, 0, 16'h1, "wr_rsv_ok");
    chk(0, K_BUSY, 0, 16'h04, "wr_rsv_busy_pre");
    chk(0, K_RDBUSY, 0, 16'h0, "byp_clears_rdbusy");
    chk(0, K_RD, 0, 16'h0BEE, "byp_r2");
    step();
    wr_a(0, 2, 16'h0C0D); rd_a(1, 3);
    chk(0, K_BUSY, 0, 16'h04, "wr_rsv_busy_kept");
    chk(0, K_RSVOK, 0, 16'h0, "rsv_idle");
    chk(0, K_RD, 1, 16'hA5A5, "r3_still");
    step();
    rd_a(0, 2);
    chk(0, K_BUSY, 0, 16'h00, "lone_wr_clears");
    chk(0, K_RD, 0, 16'h0C0D, "r2_final");
    chk(0, K_RDBUSY, 0, 16'h0, "rd_busy_cleared");
    step();

    ifb.wr_en = 1'b1; ifb.wr_addr = 3'd0; ifb.wr_data = 16'hFFFF; rd_b(0, 0);
    chk(1, K_RD, 0, 16'h0, "r0_no_byp");
    step();
    rd_b(0, 0); ifb.rsv_en = 1'b1; ifb.rsv_addr = 3'd0;
    chk(1, K_RD, 0, 16'h0, "r0_stored");
    chk(1, K_RSVOK, 0, 16'h1, "r0_rsv_ok");
    step();
    ifb.wr_en = 1'b1; ifb.wr_addr = 3'd7; ifb.wr_data = 16'h1234; rd_b(1, 7);
    chk(1, K_BUSY, 0, 16'h00, "r0_never_busy");
    chk(1, K_RD, 1, 16'h1234, "b_byp_r7");
    step();
    rd_b(1, 7);
    chk(1, K_RD, 1, 16'h1234, "b_stored_r7");
    step();

    wr_a(0, 1, 16'h00FF); ifa.rsv_en = 1'b1; ifa.rsv_addr = 3'd6;
    chk(0, K_RSVOK, 0, 16'h1, "rsv_r6");
    step();
    rd_a(0, 1); rd_a(1, 6);
    chk(0, K_RD, 0, 16'h00FF, "pre_rst_r1");
    chk(0, K_BUSY, 0, 16'h40, "pre_rst_busy");
    chk(0, K_RDBUSY, 0, 16'h2, "pre_rst_rdbusy");
    step();
    rd_a(0, 1); rd_a(1, 6); rd_b(1, 7);
    #2 rst = 1'b1;
    chk(0, K_RD, 0, 16'h0, "rst_mid_r1");
    chk(0, K_RD, 1, 16'h0, "rst_mid_r6");
    chk(0, K_BUSY, 0, 16'h0, "rst_mid_busy");
    chk(0, K_RDBUSY, 0, 16'h0, "rst_mid_rdbusy");
    chk(1, K_RD, 1, 16'h0, "rst_mid_b_r7");
    #1;
    tests++;
    if (ifa.busy_vec !== 8'h00) begin
      failed++;
      $display("FAIL rst_now_busy_a: got %h expected 00", ifa.busy_vec);
    end
    tests++;
    if (ifa.rd_data !== 32'h0) begin
      failed++;
      $display("FAIL rst_now_rd_a: got %h expected 0", ifa.rd_data);
    end
    tests++;
    if (ifa.rd_busy !== 2'b00) begin
      failed++;
      $display("FAIL rst_now_rdbusy_a: got %b expected 00", ifa.rd_busy);
    end
    tests++;
    if (ifa.rsv_ok !== 1'b0) begin
      failed++;
      $display("FAIL rst_now_rsvok_a: got %b expected 0", ifa.rsv_ok);
    end
    tests++;
    if (ifb.rd_data !== 32'h0) begin
      failed++;
      $display("FAIL rst_now_rd_b: got %h expected 0", ifb.rd_data);
    end
    tests++;
    if (ifb.busy_vec !== 8'h00) begin
      failed++;
      $display("FAIL rst_now_busy_b: got %h expected 00", ifb.busy_vec);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
